// File: rtl/signal_channel_dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signal_channel_dds_pkg
// Description : Waveform codes and control-word field positions shared by the
//               DDS channels and the MCU register block that feeds them.
// Revision    : 1.0 - initial release
// ============================================================================
package signal_channel_dds_pkg;

  typedef enum logic [2:0] {
    WAVE_SINE     = 3'd0,
    WAVE_SQUARE   = 3'd1,
    WAVE_TRIANGLE = 3'd2,
    WAVE_SAWTOOTH = 3'd3,
    WAVE_DC       = 3'd4
  } wave_e;

  localparam int CTRL_WAVE_LSB   = 0;
  localparam int CTRL_WAVE_WIDTH = 3;
  localparam int CTRL_INVERT_BIT = 3;
  localparam int CTRL_DC_LSB     = 8;

endpackage : signal_channel_dds_pkg
`default_nettype wire

// File: rtl/signal_channel_dds_sine_quarter_lut.sv
`default_nettype none
// ============================================================================
// Module      : signal_channel_dds_sine_quarter_lut
// Description : Registered quarter-wave sine ROM, one cycle read latency.
//               Entry i holds round((2^DATA_WIDTH-1) * sin(pi/2 * i/(DEPTH-1))).
// Revision    : 1.0 - initial release
// ============================================================================
module signal_channel_dds_sine_quarter_lut #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 7
) (
  input  logic                  i_main_clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int c_depth = 1 << ADDR_WIDTH;

  // Table contents are computed at elaboration in Q24 fixed point
  // (Taylor series to x^9, error far below one LSB), so no data file is needed.
  function automatic logic [c_depth*DATA_WIDTH-1:0] build_table();
    logic [c_depth*DATA_WIDTH-1:0] tbl;
    longint one;
    longint half_pi;
    longint amp;
    longint x;
    longint x2;
    longint t;
    longint s;
    longint v;
    tbl     = '0;
    one     = 64'sd16777216;
    half_pi = 64'sd26353589;
    amp     = (64'sd1 <<< DATA_WIDTH) - 64'sd1;
    for (int i = 0; i < c_depth; i++) begin
      x  = (longint'(i) * half_pi) / longint'(c_depth - 1);
      x2 = (x * x) >>> 24;
      t  = one - x2 / 72;
      t  = one - ((x2 * t) >>> 24) / 42;
      t  = one - ((x2 * t) >>> 24) / 20;
      t  = one - ((x2 * t) >>> 24) / 6;
      s  = (x * t) >>> 24;
      v  = (s * amp + (one >>> 1)) >>> 24;
      if (v > amp) v = amp;
      if (v < 0)   v = 0;
      tbl[i*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
    end
    return tbl;
  endfunction

  localparam logic [c_depth*DATA_WIDTH-1:0] c_table = build_table();

  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge i_main_clk) begin
    r_data <= c_table[int'(i_addr)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign o_data = r_data;

endmodule : signal_channel_dds_sine_quarter_lut
`default_nettype wire

// File: rtl/signal_channel_dds.sv
`default_nettype none
// ============================================================================
// Module      : signal_channel_dds
// Description : One DDS channel: 48-bit phase accumulator with separate steps
//               per half-period, two-stage waveform pipeline, registered sample.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_channel_dds
  import signal_channel_dds_pkg::*;
#(
  parameter int PHASE_WIDTH    = 48,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int LUT_ADDR_WIDTH = 8
) (
  input  logic                    i_main_clk,
  input  logic                    i_reset,
  input  logic [PHASE_WIDTH-1:0]  i_negative_step,
  input  logic [PHASE_WIDTH-1:0]  i_positive_step,
  input  logic [PHASE_WIDTH-1:0]  i_phase_add,
  input  logic [PHASE_WIDTH-1:0]  i_signal_control,
  input  logic                    i_load_step_registers,
  input  logic                    i_add_signal_phase,
  input  logic                    i_reset_signal_phase,
  output logic [SAMPLE_WIDTH-1:0] o_sample,
  output logic                    o_phase_msb
);

  localparam int                      c_msb      = PHASE_WIDTH - 1;
  localparam logic [SAMPLE_WIDTH-1:0] c_midscale = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] r_acc;
  logic [PHASE_WIDTH-1:0] r_pos_step;
  logic [PHASE_WIDTH-1:0] r_neg_step;
  logic [PHASE_WIDTH-1:0] w_step_sel;

  always_ff @(posedge i_main_clk) begin
    if (i_reset) begin
      r_pos_step <= '0;
      r_neg_step <= '0;
    end else if (i_load_step_registers) begin
      r_pos_step <= i_positive_step;
      r_neg_step <= i_negative_step;
    end
  end

  assign w_step_sel = r_acc[c_msb] ? r_neg_step : r_pos_step;

  // Half-boundary overshoot is deliberately carried, not clipped.
  always_ff @(posedge i_main_clk) begin
    if (i_reset || i_reset_signal_phase) begin
      r_acc <= '0;
    end else if (i_add_signal_phase) begin
      r_acc <= r_acc + w_step_sel + i_phase_add;
    end else begin
      r_acc <= r_acc + w_step_sel;
    end
  end

  // Stage 1: quadrant fold into the ROM, and direct waveform selection.
  logic [1:0]                w_quadrant;
  logic [LUT_ADDR_WIDTH-1:0] w_lut_index;
  logic [LUT_ADDR_WIDTH-1:0] w_lut_addr;
  logic [SAMPLE_WIDTH-2:0]   w_lut_data;
  logic [2:0]                w_wave_code;
  logic [SAMPLE_WIDTH-1:0]   w_direct_value;
  logic                      w_unused_ctrl;

  assign w_quadrant    = r_acc[c_msb -: 2];
  assign w_lut_index   = r_acc[c_msb-2 -: LUT_ADDR_WIDTH];
  assign w_lut_addr    = w_quadrant[0] ? ~w_lut_index : w_lut_index;
  assign w_wave_code   = i_signal_control[CTRL_WAVE_LSB +: CTRL_WAVE_WIDTH];
  assign w_unused_ctrl = ^i_signal_control;

  signal_channel_dds_sine_quarter_lut #(
    .ADDR_WIDTH (LUT_ADDR_WIDTH),
    .DATA_WIDTH (SAMPLE_WIDTH - 1)
  ) u_sine_lut (
    .i_main_clk (i_main_clk),
    .i_addr     (w_lut_addr),
    .o_data     (w_lut_data)
  );

  always_comb begin
    w_direct_value = c_midscale;
    case (w_wave_code)
      WAVE_SQUARE:   w_direct_value = r_acc[c_msb] ? '0 : '1;
      WAVE_TRIANGLE: w_direct_value = r_acc[c_msb] ? ~r_acc[c_msb-1 -: SAMPLE_WIDTH]
                                                   :  r_acc[c_msb-1 -: SAMPLE_WIDTH];
      WAVE_SAWTOOTH: w_direct_value = r_acc[c_msb -: SAMPLE_WIDTH];
      WAVE_DC:       w_direct_value = i_signal_control[CTRL_DC_LSB +: SAMPLE_WIDTH];
      default:       w_direct_value = c_midscale;
    endcase
  end

  logic [SAMPLE_WIDTH-1:0] r_s1_value;
  logic                    r_s1_is_sine;
  logic                    r_s1_negate;
  logic                    r_s1_invert;
  logic                    r_s1_msb;

  always_ff @(posedge i_main_clk) begin
    if (i_reset) begin
      r_s1_value   <= c_midscale;
      r_s1_is_sine <= 1'b0;
      r_s1_negate  <= 1'b0;
      r_s1_invert  <= 1'b0;
      r_s1_msb     <= 1'b0;
    end else begin
      r_s1_value   <= w_direct_value;
      r_s1_is_sine <= (w_wave_code == WAVE_SINE);
      r_s1_negate  <= w_quadrant[1];
      r_s1_invert  <= i_signal_control[CTRL_INVERT_BIT];
      r_s1_msb     <= r_acc[c_msb];
    end
  end

  // Stage 2: the lower half is the bitwise mirror of midscale+lut.
  logic [SAMPLE_WIDTH-1:0] w_sine_value;
  logic [SAMPLE_WIDTH-1:0] w_pre_invert;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_phase_msb;

  assign w_sine_value = r_s1_negate ? ~{1'b1, w_lut_data} : {1'b1, w_lut_data};
  assign w_pre_invert = r_s1_is_sine ? w_sine_value : r_s1_value;

  always_ff @(posedge i_main_clk) begin
    if (i_reset) begin
      r_sample    <= c_midscale;
      r_phase_msb <= 1'b0;
    end else begin
      r_sample    <= r_s1_invert ? ~w_pre_invert : w_pre_invert;
      r_phase_msb <= r_s1_msb;
    end
  end

  assign o_sample    = r_sample;
  assign o_phase_msb = r_phase_msb;

endmodule : signal_channel_dds
`default_nettype wire

// File: tb/tb_signal_channel_dds.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_channel_dds
// Description : Self-checking bench for one DDS channel (SAMPLE_WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_channel_dds;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        addp = 1'b0;
  logic        rph = 1'b0;
  logic [47:0] neg_step = '0;
  logic [47:0] pos_step = '0;
  logic [47:0] padd = '0;
  logic [47:0] ctrl = '0;
  logic [7:0]  sample;
  logic        msb;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  signal_channel_dds dut (
    .i_main_clk            (clk),
    .i_reset               (rst),
    .i_negative_step       (neg_step),
    .i_positive_step       (pos_step),
    .i_phase_add           (padd),
    .i_signal_control      (ctrl),
    .i_load_step_registers (load),
    .i_add_signal_phase    (addp),
    .i_reset_signal_phase  (rph),
    .o_sample              (sample),
    .o_phase_msb           (msb)
  );

  task automatic check_val(input string name, input logic [7:0] act, input int exp, input int tol);
    checks++;
    if ($isunknown(act) || (int'(act) - exp) > tol || (exp - int'(act)) > tol) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  // Sample value for phase p under control word c, from the waveform definitions.
  function automatic int expected_sample(input logic [47:0] p, input logic [47:0] c);
    int v;
    int q;
    int j;
    real m;
    q = int'(p >> 46);
    j = int'((p >> 38) % 256);
    case (int'(c[2:0]))
      0: begin
        if (q % 2 == 1) j = 255 - j;
        m = 127.0 * $sin(3.141592653589793 * j / 510.0);
        v = $rtoi(m + 0.5);
        v = (q < 2) ? 128 + v : 127 - v;
      end
      1: v = (q >= 2) ? 0 : 255;
      2: v = (q >= 2) ? 255 - int'((p >> 39) % 256) : int'((p >> 39) % 256);
      3: v = int'(p >> 40);
      4: v = int'(c[15:8]);
      default: v = 128;
    endcase
    if (c[3]) v = 255 - v;
    return v;
  endfunction

  // Model: output after edge n reflects the phase after edge n-2 and the
  // control word sampled at edge n-1; midscale for two edges from a reset.
  logic [47:0] m_acc = '0;
  logic [47:0] m_acc_d1 = '0;
  logic [47:0] m_pos = '0;
  logic [47:0] m_neg = '0;
  logic [47:0] m_ctrl = '0;
  logic        m_rst_prev = 1'b0;
  logic        m_valid = 1'b0;
  int          m_exp = 128;
  int          m_tol = 0;
  logic        m_exp_msb = 1'b0;

  always @(posedge clk) begin
    m_rst_prev <= rst;
    m_ctrl     <= ctrl;
    m_acc_d1   <= m_acc;
    if (rst || m_rst_prev) begin
      m_exp     <= 128;
      m_tol     <= 0;
      m_exp_msb <= 1'b0;
    end else begin
      m_exp     <= expected_sample(m_acc_d1, m_ctrl);
      m_tol     <= (m_ctrl[2:0] == 3'd0) ? 1 : 0;
      m_exp_msb <= m_acc_d1[47];
    end
    if (rst) begin
      m_acc   <= '0;
      m_pos   <= '0;
      m_neg   <= '0;
      m_valid <= 1'b1;
    end else begin
      if (rph) m_acc <= '0;
      else     m_acc <= m_acc + (m_acc[47] ? m_neg : m_pos) + (addp ? padd : 48'd0);
      if (load) begin
        m_pos <= pos_step;
        m_neg <= neg_step;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_val("model_sample", sample, m_exp, m_tol);
      check_val("model_phase_msb", {7'd0, msb}, int'(m_exp_msb), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobes are held for exactly one rising edge.
  task automatic pulse(input logic r, input logic l, input logic a, input logic ph);
    @(negedge clk);
    rst  = r;
    load = l;
    addp = a;
    rph  = ph;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    addp = 1'b0;
    rph  = 1'b0;
  endtask

  initial begin
    step(3);
    check_val("reset_sample", sample, 8'h80, 0);
    check_val("reset_msb", {7'd0, msb}, 0, 0);
    rst = 1'b0;

    // Sawtooth at one LSB per clock
    pos_step = 48'h010000000000;
    neg_step = 48'h010000000000;
    ctrl     = 48'd3;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step(2);   check_val("saw_first", sample, 8'h00, 0);
    step(1);   check_val("saw_inc", sample, 8'h01, 0);
    step(126); check_val("saw_msb_low", {7'd0, msb}, 0, 0);
    step(1);   check_val("saw_msb_high", {7'd0, msb}, 1, 0);
               check_val("saw_mid", sample, 8'h80, 0);
    step(127); check_val("saw_top", sample, 8'hFF, 0);
    step(1);   check_val("saw_wrap", sample, 8'h00, 0);

    // Reset mid-run overrides simultaneous strobes
    padd = 48'h400000000000;
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("rst_midrun", sample, 8'h80, 0);
    check_val("rst_midrun_msb", {7'd0, msb}, 0, 0);
    step(1);   check_val("rst_hold", sample, 8'h80, 0);
    step(1);   check_val("rst_release", sample, 8'h00, 0);
    step(3);   check_val("rst_steps_cleared", sample, 8'h00, 0);
    padd = '0;

    // Asymmetric square: 64 high, 256 low
    pos_step = 48'h020000000000;
    neg_step = 48'h008000000000;
    ctrl     = 48'd1;
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    step(2);   check_val("sq_high_start", sample, 8'hFF, 0);
    step(63);  check_val("sq_high_end", sample, 8'hFF, 0);
    step(1);   check_val("sq_low_start", sample, 8'h00, 0);
    step(34);
    pos_step = 48'd1;
    neg_step = 48'd1;
    step(221); check_val("sq_low_end", sample, 8'h00, 0);
    step(1);   check_val("sq_high_again", sample, 8'hFF, 0);
    step(63);  check_val("sq_high_end2", sample, 8'hFF, 0);
    step(1);   check_val("sq_low_again", sample, 8'h00, 0);

    // Phase add, then add+reset in the same cycle
    pos_step = '0;
    neg_step = '0;
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    ctrl = 48'd3;
    padd = 48'h400000000000;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    step(1);   check_val("add_before", sample, 8'h00, 0);
    step(1);   check_val("add_applied", sample, 8'h40, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("add_rst_hold0", sample, 8'h40, 0);
    step(1);   check_val("add_rst_hold1", sample, 8'h40, 0);
    step(1);   check_val("add_rst_cleared", sample, 8'h00, 0);
    padd = '0;

    // Sine and inverted sine
    pos_step = 48'h010000000000;
    neg_step = 48'h010000000000;
    ctrl     = 48'd0;
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    step(2);   check_val("sine_0", sample, 8'h80, 0);
    step(64);  check_val("sine_40", sample, 8'hFF, 0);
    step(64);  check_val("sine_80", sample, 8'h80, 1);
    step(64);  check_val("sine_C0", sample, 8'h00, 0);
    ctrl = 48'd8;
    step(64);  check_val("sine_inv_0", sample, 8'h7F, 0);
    step(64);  check_val("sine_inv_40", sample, 8'h00, 0);

    // DC level and unused code
    ctrl = 48'h5A04;
    step(2);   check_val("dc_level", sample, 8'h5A, 0);
    ctrl = 48'd6;
    step(2);   check_val("unused_midscale", sample, 8'h80, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_signal_channel_dds
`default_nettype wire
